// File: rtl/ps2_rx_pkg.sv
// PS/2 receiver shared types and constants.
// Prefix/ignore codes, bus bit positions, FSM states.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  localparam logic [7:0] DROP_ACK  = 8'hFA;
  localparam logic [7:0] DROP_BAT  = 8'hAA;
  localparam logic [7:0] DROP_ECHO = 8'hEE;
  localparam logic [7:0] DROP_RSND = 8'hFE;
  localparam logic [7:0] DROP_ERR0 = 8'h00;
  localparam logic [7:0] DROP_ERR1 = 8'hFF;
  localparam logic [7:0] DROP_PAUS = 8'hE1;

  localparam int BIT_TOGGLE = 10;
  localparam int BIT_BREAK  = 9;
  localparam int BIT_EXT    = 8;

  function automatic logic is_drop(
    input logic [7:0] b
  );
    return (b == DROP_ACK)  ||
           (b == DROP_BAT)  ||
           (b == DROP_ECHO) ||
           (b == DROP_RSND) ||
           (b == DROP_ERR0) ||
           (b == DROP_ERR1) ||
           (b == DROP_PAUS);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// 2-flop synchronizer plus glitch filter for the PS/2 clock line.
// Ports: clock/reset, raw_i line in, fall_o one-cycle pulse on filtered 1->0.
module ps2_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after FILTER consecutive differing samples.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(FILTER - 1)) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      lvl_q  <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      cnt_q  <= cnt_d;
    end
  end

  assign fall_o = prev_q & ~lvl_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into events.
// Ports: clock, reset (async low), ps2Ck/ps2D raw lines, ps2 event bus, err pulse.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2Ck,
  input  logic        ps2D,
  output logic [10:0] ps2,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    dsync_q;
  logic          edge_s;
  logic          din;

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [10:0]   bus_q, bus_d;
  logic          err_q, err_d;
  logic          tmo;

  ps2_filter #(
    .FILTER (FILTER)
  ) u_ck (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (ps2Ck),
    .fall_o (edge_s)
  );

  assign din = dsync_q[1];

  assign tmo = (state_q != S_IDLE) && !edge_s &&
               (to_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    bus_d   = bus_q;
    err_d   = 1'b0;
    to_d    = (edge_s || state_q == S_IDLE) ? '0 : to_q + TW'(1);

    if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (edge_s) begin
      case (state_q)
        S_IDLE: begin
          if (!din) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          sh_d  = {din, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          // Odd parity over data+parity and a high stop bit.
          if (din && ^{sh_q, par_q}) begin
            unique case (1'b1)
              (sh_q == CODE_EXT): ext_d = 1'b1;
              (sh_q == CODE_BRK): brk_d = 1'b1;
              is_drop(sh_q): begin
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
              default: begin
                bus_d[BIT_TOGGLE] = ~bus_q[BIT_TOGGLE];
                bus_d[BIT_BREAK]  = brk_q;
                bus_d[BIT_EXT]    = ext_q;
                bus_d[7:0]        = sh_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
            endcase
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dsync_q <= 2'b11;
      state_q <= S_IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      bus_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      dsync_q <= {dsync_q[0], ps2D};
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
    end
  end

  assign ps2 = bus_q;
  assign err = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed PS/2 frames,
// expected events queued, monitor pops on bus change or err.
module tb_ps2_rx;

  localparam int FILT = 8;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic        clock;
  logic        reset;
  logic        ps2Ck;
  logic        ps2D;
  logic [10:0] ps2;
  logic        err;

  typedef struct {
    bit          is_err;
    logic [10:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  vectors;
  int  miscompares;

  ps2_rx #(
    .FILTER  (FILT),
    .TIMEOUT (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ps2Ck (ps2Ck),
    .ps2D  (ps2D),
    .ps2   (ps2),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic chk(input string nm, input logic [10:0] act,
                     input logic [10:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic push_bus(input logic [10:0] v);
    ev_t e;
    e.is_err = 1'b0;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.val    = '0;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input bit is_err, input logic [10:0] v);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s: got %h want none",
               is_err ? "err" : "bus", v);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err || (!is_err && e.val !== v)) begin
        miscompares++;
        $display("FAIL event: got %s %h want %s %h",
                 is_err ? "err" : "bus", v,
                 e.is_err ? "err" : "bus", e.val);
      end
    end
  endtask

  // glitch=1 puts a FILT-1 cycle low pulse in the clock-high phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2D = b;
    if (glitch) begin
      cyc(16);
      ps2Ck = 1'b0;
      cyc(FILT - 1);
      ps2Ck = 1'b1;
      cyc(HALF);
    end else begin
      cyc(HALF);
    end
    ps2Ck = 1'b0;
    cyc(HALF);
    ps2Ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int glitch_bit);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i);
    send_bit(p, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2D = 1'b1;
    cyc(3 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] b);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i], 1'b0);
    ps2D = 1'b1;
  endtask

  // Monitor: every err cycle and every bus change is one event.
  initial begin
    logic [10:0] prev;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev = ps2;
      end else begin
        if (err) check_ev(1'b1, 11'h000);
        if (ps2 !== prev) begin
          check_ev(1'b0, ps2);
          prev = ps2;
        end
      end
    end
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    ps2Ck = 1'b1;
    ps2D  = 1'b1;
    reset = 1'b0;
    cyc(4);
    @(negedge clock);
    chk("reset_ps2", ps2, 11'h000);
    chk("reset_err", {10'd0, err}, 11'h000);
    reset = 1'b1;
    cyc(10);

    push_bus(11'h41C);
    send_frame(8'h1C, 1'b0, -1);

    push_bus(11'h21C);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1);

    push_bus(11'h775);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);

    push_err();
    send_frame(8'h16, 1'b1, -1);
    push_bus(11'h016);
    send_frame(8'h16, 1'b0, -1);

    push_err();
    send_partial(8'h29);
    cyc(TMO + 50);
    push_bus(11'h429);
    send_frame(8'h29, 1'b0, -1);

    push_bus(11'h05A);
    send_frame(8'h5A, 1'b0, 4);
    send_frame(8'hFA, 1'b0, -1);

    push_bus(11'h474);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'hAA, 1'b0, -1);
    send_frame(8'h74, 1'b0, -1);

    cyc(20);
    send_partial(8'h3C);
    cyc(5);
    reset = 1'b0;
    ps2Ck = 1'b1;
    cyc(5);
    @(negedge clock);
    chk("midreset_ps2", ps2, 11'h000);
    chk("midreset_err", {10'd0, err}, 11'h000);
    reset = 1'b1;
    cyc(10);

    push_bus(11'h41C);
    send_frame(8'h1C, 1'b0, -1);

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    cyc(50);
    chk("queue_drained", 11'(exp_q.size()), 11'h000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER, default 8, meaning consecutive equal samples needed to accept a PS/2 clock level change.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, meaning clock cycles allowed between PS/2 clock falling edges before an in-progress frame is abandoned.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2Ck  input  1  raw PS/2 clock line, asynchronous to clock.
REQ-006 SHALL have port ps2D  input  1  raw PS/2 data line, asynchronous to clock.
REQ-007 SHALL have port ps2  output  11  scancode event bus: [10] toggle (inverts once per event), [9] break (1 = key released), [8] extended (E0-prefixed), [7:0] scancode.
REQ-008 SHALL have port err  output  1  one-cycle pulse on any discarded frame.

Function
REQ-009 SHALL pass ps2Ck and ps2D each through a 2-flop synchronizer before any use.
REQ-010 SHALL change filtered clock only after FILTER consecutive synchronized samples differ from its current value; shorter glitches ignored.
REQ-011 SHALL sample synchronized ps2D on each filtered-clock 1->0 transition (the "edge").
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no err.
REQ-014 DATA: shift in bits LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: capture bit -> STOP; frame parity valid when 8 data bits plus parity bit contain an odd number of ones.
REQ-016 STOP: edge -> IDLE; frame accepted only if stop bit is 1 and parity valid, else discarded with err pulse.
REQ-017 Edge counter SHALL reset on every edge; in any state other than IDLE, reaching TIMEOUT cycles -> IDLE, discard partial frame, pulse err, clear prefix flags.
REQ-018 Accepted byte 8'hE0 SHALL set ext flag; no bus update.
REQ-019 Accepted byte 8'hF0 SHALL set brk flag; no bus update.
REQ-020 Accepted bytes 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1 SHALL be dropped silently, flags cleared, no err.
REQ-021 Any other accepted byte SHALL, on the cycle after the stop-bit edge, load ps2[7:0]=byte, ps2[9]=brk, ps2[8]=ext, invert ps2[10], then clear both flags in the same cycle.
REQ-022 ps2[9:0] SHALL hold until next event; exactly one toggle inversion per event.
REQ-023 Discarded frames (parity, stop, timeout) SHALL clear brk and ext flags.
REQ-024 err SHALL assert exactly one cycle per discarded frame, coincident with the return to IDLE.

Reset
REQ-025 While reset=0: ps2=11'h000, err=0, state IDLE, flags 0, counters 0, synchronizers and filtered clock at 1.
REQ-026 Reset mid-frame SHALL discard the frame; first edge after release treated as a potential start bit.

Structure
REQ-027 Shared package SHALL hold prefix/ignore code constants (E0, F0, drop list) and ps2 bus bit-position constants (TOGGLE=10, BREAK=9, EXT=8).
REQ-028 Synchronizer plus glitch filter SHALL be one sub-module ps2_filter, instantiated for the clock line; data uses synchronizer only.
REQ-029 Counters sized by $clog2 of parameters; no other sub-modules.

Verification
REQ-030 Frame 8'h1C (A), parity 0, stop 1 -> ps2=11'h41C (toggle 1, break 0, ext 0), err 0.
REQ-031 Frames F0 then 1C -> only one update, ps2[9]=1, ps2[7:0]=8'h1C, toggle inverted once.
REQ-032 Frames E0, F0, 75 -> ps2[9:0]=10'h375, single toggle.
REQ-033 Frame 8'h16 with wrong parity -> no bus change, one err pulse; following good frame 8'h16 -> ps2[7:0]=8'h16, break 0.
REQ-034 Four bits of a frame then clock held high TIMEOUT cycles -> err pulse, return to IDLE; next full frame 8'h29 decoded correctly.
REQ-035 Clock glitch of FILTER-1 cycles during DATA -> ignored, frame 8'h5A decoded; frame 8'hFA -> no update, no err.
